// File: rtl/emu_selfwrite_loader_pkg.sv
// Shared types and constants for the emulation self-write bitstream loader.
package emu_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [WORD_W-1:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;
    localparam logic [CNT_W-1:0]  MAX_WORDS_DEFAULT = 16'd4096;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_DATA,
        ST_STROBE,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/emu_selfwrite_loader_if.sv
// Byte stream channel into the loader. A byte moves on any cycle where
// byte_valid and byte_ready are both high; byte_data must be stable while valid.
interface emu_loader_if;
    import emu_loader_pkg::*;

    logic [BYTE_W-1:0] byte_data;
    logic              byte_valid;
    logic              byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/emu_selfwrite_loader_assembler.sv
// Packs MSB-first bytes into 32-bit words; shared by the length and data phases.
module emu_word_assembler
    import emu_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              xfer,
    input  logic              clear,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_complete
);

    // Only the three newest bytes need storing: the fourth is the byte in flight,
    // so `word` is the post-shift value available in the transfer cycle.
    logic [WORD_W-BYTE_W-1:0] hist_q, hist_d;
    logic [1:0]               idx_q, idx_d;

    always_comb begin
        hist_d = hist_q;
        idx_d  = idx_q;
        if (clear) begin
            hist_d = '0;
            idx_d  = '0;
        end else if (xfer) begin
            hist_d = {hist_q[WORD_W-2*BYTE_W-1:0], byte_in};
            idx_d  = idx_q + 2'd1;
        end
    end

    assign word          = {hist_q, byte_in};
    assign word_complete = xfer && (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            idx_q  <= '0;
        end else begin
            hist_q <= hist_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/emu_selfwrite_loader.sv
// Hunts for the sync word, reads a word count, then strobes each 32-bit
// configuration word into the fabric with a fixed idle gap after every strobe.
module emu_selfwrite_loader
    import emu_loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] SYNC_WORD  = SYNC_WORD_DEFAULT,
    parameter logic [CNT_W-1:0]  MAX_WORDS  = MAX_WORDS_DEFAULT,
    parameter int                GAP_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    emu_loader_if.slave       in_if,
    input  logic              rearm,
    output logic              SelfWriteStrobe,
    output logic [WORD_W-1:0] SelfWriteData,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  word_count,
    output state_e            state_dbg
);

    localparam logic [7:0] GAP_INIT = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              strobe_q, strobe_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  wc_q, wc_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [7:0]        gap_q, gap_d;

    logic              xfer;
    logic              asm_clear;
    logic [WORD_W-1:0] asm_word;
    logic              asm_done;

    assign xfer = in_if.byte_valid && ready_q;

    emu_word_assembler u_asm (
        .clk           (CLK),
        .rst           (RST),
        .xfer          (xfer),
        .clear         (asm_clear),
        .byte_in       (in_if.byte_data),
        .word          (asm_word),
        .word_complete (asm_done)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        wc_d      = wc_q;
        n_d       = n_q;
        gap_d     = gap_q;
        asm_clear = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (xfer && asm_word == SYNC_WORD) begin
                    state_d   = ST_LEN;
                    asm_clear = 1'b1;
                    wc_d      = '0;
                end
            end
            ST_LEN: begin
                if (asm_done) begin
                    if (asm_word[31:16] != 16'd0 || asm_word[15:0] == 16'd0 ||
                        asm_word[15:0] > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = asm_word[15:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (asm_done) begin
                    data_d  = asm_word;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                wc_d = wc_q + 16'd1;
                if (GAP_CYCLES > 0) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_INIT;
                end else begin
                    state_d = (wc_q + 16'd1 == n_q) ? ST_DONE : ST_DATA;
                end
            end
            ST_GAP: begin
                if (gap_q == 8'd0) state_d = (wc_q == n_q) ? ST_DONE : ST_DATA;
                else               gap_d   = gap_q - 8'd1;
            end
            ST_DONE, ST_ERR: begin
                if (rearm) begin
                    state_d   = ST_HUNT;
                    asm_clear = 1'b1;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // Status outputs are decoded from the next state so they register in step with it.
        ready_d  = (state_d == ST_HUNT) || (state_d == ST_LEN) || (state_d == ST_DATA);
        strobe_d = (state_d == ST_STROBE);
        busy_d   = (state_d == ST_LEN) || (state_d == ST_DATA) ||
                   (state_d == ST_STROBE) || (state_d == ST_GAP);
        done_d   = (state_d == ST_DONE);
        err_d    = (state_d == ST_ERR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_HUNT;
            ready_q  <= 1'b1;
            strobe_q <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wc_q     <= '0;
            n_q      <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            strobe_q <= strobe_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wc_q     <= wc_d;
            n_q      <= n_d;
            gap_q    <= gap_d;
        end
    end

    assign in_if.byte_ready = ready_q;
    assign SelfWriteStrobe  = strobe_q;
    assign SelfWriteData    = data_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = err_q;
    assign word_count       = wc_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_emu_selfwrite_loader.sv
// Directed bench for the self-write loader: table of whole loads, plus sequences
// for gap timing, mid-word reset, stalls and a zero-gap build.
module tb_emu_selfwrite_loader;
  import emu_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // DUT A: GAP_CYCLES=2
  emu_loader_if a_if();
  logic        a_rst = 1'b1;
  logic        a_rearm = 1'b0;
  logic        a_strobe, a_busy, a_done, a_err;
  logic [31:0] a_data;
  logic [15:0] a_wc;
  state_e      a_st;

  // DUT B: GAP_CYCLES=0
  emu_loader_if b_if();
  logic        b_rst = 1'b1;
  logic        b_rearm = 1'b0;
  logic        b_strobe, b_busy, b_done, b_err;
  logic [31:0] b_data;
  logic [15:0] b_wc;
  state_e      b_st;

  emu_selfwrite_loader #(.GAP_CYCLES(2)) dut_a (
    .CLK(clk), .RST(a_rst), .in_if(a_if), .rearm(a_rearm),
    .SelfWriteStrobe(a_strobe), .SelfWriteData(a_data), .busy(a_busy),
    .done(a_done), .error(a_err), .word_count(a_wc), .state_dbg(a_st)
  );

  emu_selfwrite_loader #(.GAP_CYCLES(0)) dut_b (
    .CLK(clk), .RST(b_rst), .in_if(b_if), .rearm(b_rearm),
    .SelfWriteStrobe(b_strobe), .SelfWriteData(b_data), .busy(b_busy),
    .done(b_done), .error(b_err), .word_count(b_wc), .state_dbg(b_st)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  bit stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard on DUT A strobes: data order, no back-to-back strobes, data held between strobes
  logic        a_prev = 1'b0;
  logic [31:0] a_last = '0;
  int          a_strobes = 0;
  always @(negedge clk) begin
    if (a_rst) begin
      a_prev = 1'b0;
      a_last = '0;
    end else begin
      if (a_strobe) begin
        a_strobes++;
        check("strobe_not_consecutive", {31'd0, a_prev}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got data %h expected no strobe", a_data);
        end else begin
          check("strobe_data", a_data, exp_q.pop_front());
        end
        a_last = a_data;
      end else begin
        check("data_stable", a_data, a_last);
      end
      a_prev = a_strobe;
    end
  end

  // DUT B strobe/done timing log
  int          b_times[$];
  logic [31:0] b_datas[$];
  int          b_done_cyc = -1;
  always @(negedge clk) begin
    if (!b_rst) begin
      if (b_strobe) begin
        b_times.push_back(cyc);
        b_datas.push_back(b_data);
      end
      if (b_done && b_done_cyc < 0) b_done_cyc = cyc;
    end
  end

  task automatic send(input bit sel, input logic [7:0] b);
    int t;
    t = 0;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    if (sel) begin b_if.byte_data = b; b_if.byte_valid = 1'b1; end
    else     begin a_if.byte_data = b; a_if.byte_valid = 1'b1; end
    @(negedge clk);
    while (!(sel ? b_if.byte_ready : a_if.byte_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h never accepted, expected acceptance", b);
    end
    @(posedge clk);
    #1;
    if (sel) b_if.byte_valid = 1'b0;
    else     a_if.byte_valid = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(sel, w[i*8 +: 8]);
  endtask

  task automatic reset_a();
    a_rst = 1'b1;
    @(posedge clk);
    #1;
    a_rst = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  typedef struct {
    string       name;
    bit          junk;
    logic [31:0] len;
    int          nw;
    logic [31:0] w[3];
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s0;
    a_if.byte_data = '0; a_if.byte_valid = 1'b0;
    b_if.byte_data = '0; b_if.byte_valid = 1'b0;

    vecs[0] = '{name:"basic2",   junk:1'b0, len:32'h0000_0002, nw:2,
                w:'{32'hDEAD_BEEF, 32'h0123_4567, 32'h0}, exp_err:1'b0};
    vecs[1] = '{name:"len0",     junk:1'b0, len:32'h0000_0000, nw:0,
                w:'{32'h0, 32'h0, 32'h0}, exp_err:1'b1};
    vecs[2] = '{name:"len1001",  junk:1'b0, len:32'h0000_1001, nw:0,
                w:'{32'h0, 32'h0, 32'h0}, exp_err:1'b1};
    vecs[3] = '{name:"len10001", junk:1'b0, len:32'h0001_0001, nw:0,
                w:'{32'h0, 32'h0, 32'h0}, exp_err:1'b1};
    vecs[4] = '{name:"misalign", junk:1'b1, len:32'h0000_0001, nw:1,
                w:'{32'h0000_00FF, 32'h0, 32'h0}, exp_err:1'b0};
    vecs[5] = '{name:"syncdata", junk:1'b0, len:32'h0000_0003, nw:3,
                w:'{32'hFAB0_FAB1, 32'h0000_0000, 32'hFAB0_FAB1}, exp_err:1'b0};

    // Reset values
    reset_a();
    check("rst_ready",  {31'd0, a_if.byte_ready}, 32'd1);
    check("rst_strobe", {31'd0, a_strobe}, 32'd0);
    check("rst_data",   a_data, 32'd0);
    check("rst_busy",   {31'd0, a_busy}, 32'd0);
    check("rst_done",   {31'd0, a_done}, 32'd0);
    check("rst_error",  {31'd0, a_err}, 32'd0);
    check("rst_wc",     {16'd0, a_wc}, 32'd0);
    check("rst_state",  32'(a_st), 32'(ST_HUNT));

    // Table of whole loads
    for (int v = 0; v < 6; v++) begin
      reset_a();
      s0 = a_strobes;
      if (vecs[v].junk) begin send(0, 8'h55); send(0, 8'hFA); end
      send_word(0, SYNC_WORD_DEFAULT);
      check({vecs[v].name, "_busy_len"}, {31'd0, a_busy}, 32'd1);
      send_word(0, vecs[v].len);
      for (int i = 0; i < vecs[v].nw; i++) begin
        exp_q.push_back(vecs[v].w[i]);
        send_word(0, vecs[v].w[i]);
      end
      wait_cycles(6);
      check({vecs[v].name, "_error"},   {31'd0, a_err}, {31'd0, vecs[v].exp_err});
      check({vecs[v].name, "_done"},    {31'd0, a_done}, {31'd0, !vecs[v].exp_err});
      check({vecs[v].name, "_busy"},    {31'd0, a_busy}, 32'd0);
      check({vecs[v].name, "_ready"},   {31'd0, a_if.byte_ready}, 32'd0);
      check({vecs[v].name, "_wc"},      {16'd0, a_wc}, 32'(vecs[v].nw));
      check({vecs[v].name, "_strobes"}, 32'(a_strobes - s0), 32'(vecs[v].nw));
      check({vecs[v].name, "_pending"}, 32'(exp_q.size()), 32'd0);
      a_rearm = 1'b1;
      wait_cycles(1);
      a_rearm = 1'b0;
      check({vecs[v].name, "_rearm_ready"}, {31'd0, a_if.byte_ready}, 32'd1);
      check({vecs[v].name, "_rearm_state"}, 32'(a_st), 32'(ST_HUNT));
      check({vecs[v].name, "_rearm_flags"}, {30'd0, a_done, a_err}, 32'd0);
      check({vecs[v].name, "_rearm_wc"},    {16'd0, a_wc}, 32'(vecs[v].nw));
    end

    // Gap timing: strobe the cycle after the 4th byte, then ready low for 3 cycles
    reset_a();
    send_word(0, SYNC_WORD_DEFAULT);
    send_word(0, 32'd2);
    exp_q.push_back(32'hDEAD_BEEF);
    send_word(0, 32'hDEAD_BEEF);
    check("gap_strobe_c0", {31'd0, a_strobe}, 32'd1);
    check("gap_ready_c0",  {31'd0, a_if.byte_ready}, 32'd0);
    check("gap_wc_c0",     {16'd0, a_wc}, 32'd0);
    wait_cycles(1);
    check("gap_ready_c1",  {31'd0, a_if.byte_ready}, 32'd0);
    check("gap_wc_c1",     {16'd0, a_wc}, 32'd1);
    wait_cycles(1);
    check("gap_ready_c2",  {31'd0, a_if.byte_ready}, 32'd0);
    wait_cycles(1);
    check("gap_ready_c3",  {31'd0, a_if.byte_ready}, 32'd1);
    exp_q.push_back(32'h0123_4567);
    send_word(0, 32'h0123_4567);
    wait_cycles(2);
    check("gap_done_early", {31'd0, a_done}, 32'd0);
    wait_cycles(1);
    check("gap_done", {31'd0, a_done}, 32'd1);

    // Reset after 2 bytes of word 3 of 5, then a clean reload
    reset_a();
    send_word(0, SYNC_WORD_DEFAULT);
    send_word(0, 32'd5);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'hA000_0000 + 32'(i));
      send_word(0, 32'hA000_0000 + 32'(i));
    end
    send(0, 8'hA0); send(0, 8'h00);
    s0 = a_strobes;
    a_rst = 1'b1;
    wait_cycles(1);
    a_rst = 1'b0;
    check("mid_rst_ready",  {31'd0, a_if.byte_ready}, 32'd1);
    check("mid_rst_strobe", {31'd0, a_strobe}, 32'd0);
    check("mid_rst_data",   a_data, 32'd0);
    check("mid_rst_flags",  {29'd0, a_busy, a_done, a_err}, 32'd0);
    check("mid_rst_wc",     {16'd0, a_wc}, 32'd0);
    check("mid_rst_state",  32'(a_st), 32'(ST_HUNT));
    wait_cycles(3);
    check("mid_rst_nostrobe", 32'(a_strobes - s0), 32'd0);
    a_rearm = 1'b1;
    send_word(0, SYNC_WORD_DEFAULT);
    send_word(0, 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) a_rearm = 1'b0;
      exp_q.push_back(32'hB000_0000 + 32'(i * 32'h0101));
      send_word(0, 32'hB000_0000 + 32'(i * 32'h0101));
    end
    wait_cycles(6);
    check("reload_done", {31'd0, a_done}, 32'd1);
    check("reload_wc",   {16'd0, a_wc}, 32'd5);
    check("reload_pending", 32'(exp_q.size()), 32'd0);

    // Random byte_valid gaps over 8 words
    reset_a();
    stall = 1'b1;
    send_word(0, SYNC_WORD_DEFAULT);
    send_word(0, 32'd8);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'h1357_9BDF ^ (32'(i) * 32'h1111_1111));
      send_word(0, 32'h1357_9BDF ^ (32'(i) * 32'h1111_1111));
    end
    stall = 1'b0;
    wait_cycles(6);
    check("stall_done", {31'd0, a_done}, 32'd1);
    check("stall_wc",   {16'd0, a_wc}, 32'd8);
    check("stall_pending", 32'(exp_q.size()), 32'd0);

    // Zero-gap build: strobes 5 cycles apart, done the cycle after the last
    b_rst = 1'b1;
    wait_cycles(1);
    b_rst = 1'b0;
    send_word(1, SYNC_WORD_DEFAULT);
    send_word(1, 32'd3);
    send_word(1, 32'h1111_0001);
    send_word(1, 32'h2222_0002);
    send_word(1, 32'h3333_0003);
    wait_cycles(5);
    check("g0_strobes", 32'(b_times.size()), 32'd3);
    if (b_times.size() == 3) begin
      check("g0_space01", 32'(b_times[1] - b_times[0]), 32'd5);
      check("g0_space12", 32'(b_times[2] - b_times[1]), 32'd5);
      check("g0_data0", b_datas[0], 32'h1111_0001);
      check("g0_data1", b_datas[1], 32'h2222_0002);
      check("g0_data2", b_datas[2], 32'h3333_0003);
      check("g0_done_cycle", 32'(b_done_cyc), 32'(b_times[2] + 1));
    end
    check("g0_wc", {16'd0, b_wc}, 32'd3);
    check("g0_flags", {29'd0, b_busy, b_done, b_err}, 32'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/emu_selfwrite_loader.md
Name: emu_selfwrite_loader

Overview:
- Byte-stream bitstream loader that drives the fabric's SelfWriteStrobe/SelfWriteData configuration port in emulation builds; sits directly upstream of eFPGA_top.
- Accepts bytes over a valid/ready interface, hunts for the sync word, reads a word-count header, then issues one single-cycle strobe per 32-bit configuration word with an enforced inter-strobe gap.
- Reports busy/done/error for board LEDs.

Parameters:
- SYNC_WORD, 32'hFAB0_FAB1, header pattern that starts a load
- MAX_WORDS, 16'd4096, largest accepted word count; larger counts are an error
- GAP_CYCLES, 2, idle cycles after each strobe before the next byte is accepted (0 allowed)

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- byte_data  in  8  incoming bitstream byte, MSB-first within each word
- byte_valid  in  1  byte_data valid
- byte_ready  out  1  loader accepts byte this cycle (transfer = valid & ready)
- rearm  in  1  from DONE or ERR, return to HUNT
- SelfWriteStrobe  out  1  one-cycle config write pulse to fabric
- SelfWriteData  out  32  config word; stable from its strobe until the next strobe
- busy  out  1  state is LEN, DATA, STROBE or GAP
- done  out  1  state is DONE
- error  out  1  state is ERR
- word_count  out  16  words strobed since last sync

Behaviour:
- Single clock CLK; RST is synchronous, active-high, and has priority over all other inputs.
- Reset values: state=HUNT, byte_ready=1, SelfWriteStrobe=0, SelfWriteData=0, busy=0, done=0, error=0, word_count=0, byte counter=0, shift register=0.
- Assembly: on each transfer, shift_reg <= {shift_reg[23:0], byte_data}.
- HUNT:
  - byte_ready=1.
  - Sliding match: if the post-shift value equals SYNC_WORD, go to LEN, clear the byte counter and word_count.
  - Non-aligned sync is found (e.g. junk byte then sync).
- LEN:
  - byte_ready=1; collect 4 bytes.
  - On the 4th: N=word[15:0]. If word[31:16]!=0, N==0 or N>MAX_WORDS, go to ERR; else latch N and go to DATA.
- DATA:
  - byte_ready=1; collect 4 bytes.
  - On the 4th transfer: SelfWriteData <= assembled word, go to STROBE.
- STROBE (1 cycle):
  - SelfWriteStrobe=1, byte_ready=0, word_count increments.
  - Strobe therefore appears the cycle after the 4th byte is accepted.
  - Next state is GAP if GAP_CYCLES>0; otherwise DATA, or DONE when word_count reaches N.
- GAP:
  - byte_ready=0 for exactly GAP_CYCLES cycles (down-counter).
  - Then DATA, or DONE when word_count==N.
- DONE/ERR:
  - byte_ready=0; outputs held; word_count frozen.
  - rearm=1 goes to HUNT next cycle, clearing the byte counter and shift register. word_count and SelfWriteData are kept until the next sync.
  - rearm is ignored in all other states.
- Sync inside payload is not special: within LEN/DATA every byte is data.
- byte_valid low mid-word: assembly pauses with no timeout; partial bytes are retained.
- RST mid-load: abort immediately. No strobe is issued for a partial word; the loader returns to HUNT.
- SelfWriteStrobe is never high on two consecutive cycles; at GAP_CYCLES=0 the minimum spacing is 5 cycles (4 bytes + strobe).
- word_count arithmetic: 16-bit, never exceeds N ≤ MAX_WORDS, so no wrap.

Decomposition:
- Shared package emu_loader_pkg holds:
  - state enum {HUNT, LEN, DATA, STROBE, GAP, DONE, ERR}
  - SYNC_WORD default constant
  - byte/word width constants
- One natural sub-module, emu_word_assembler:
  - inputs: byte transfer, clear
  - outputs: 32-bit shift register, 2-bit byte index, word_complete pulse
  - reused by LEN and DATA; the FSM, gap counter and word counter stay in the top module.

Test Plan:
- Basic load (GAP_CYCLES=2): stream FA B0 FA B1, 00 00 00 02, DE AD BE EF, 01 23 45 67 with valid held high -> two strobes, data 0xDEADBEEF then 0x01234567; ready low for 3 cycles after each word; done=1, word_count=2.
- Misaligned sync: junk 55 FA FA B0 FA B1 then length 1 and word 0x0000_00FF -> exactly one strobe with data 0x000000FF; no strobe during hunt.
- Bad length, each case from reset -> error=1, zero strobes, byte_ready=0; then rearm=1 -> HUNT, ready=1:
  - length 0x0000_0000
  - length 0x0000_1001 (MAX_WORDS=4096)
  - length 0x0001_0001
- Backpressure and stalls: random byte_valid gaps (≈50% duty) over 8 words -> strobe data matches the sequence; no consecutive strobes; SelfWriteData stable between strobes.
- Reset mid-word: RST pulse after 2 bytes of word 3 of 5 -> no further strobes, all outputs at reset values the next cycle; a fresh full stream then loads 5 words correctly.
- GAP_CYCLES=0 build: 3-word load with valid always high -> strobes exactly 5 cycles apart; done on the cycle after the 3rd strobe.
